// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-host single-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {
        HostData  = 1'b0,
        HostInstr = 1'b1
    } host_e;

    localparam int unsigned RamWordBytes = 4;

    // Byte address falls inside [base, base + depth*4); addr[1:0] cannot change the outcome
    // because the window is word aligned.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [31:0] span;
        span = 32'(depth * RamWordBytes);
        return (addr >= base) && (addr < base + span);
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker; bit 0 is the data host, bit 1 the instruction host.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    host_e prio_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (prio_q == HostInstr) ? 2'b10 : 2'b01;
        end
    end

    // Preference always hands over to the host that did not just win.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= HostData;
        end else if (gnt[0]) begin
            prio_q <= HostInstr;
        end else if (gnt[1]) begin
            prio_q <= HostData;
        end
    end

endmodule

// File: rtl/ram_1p_arbiter.sv
// Shares one single-port, one-cycle-latency word RAM between the data and fetch ports,
// answering out-of-window accesses locally with an error response.
module ram_1p_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0010_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        granted;
    host_e       winner;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        sel_in_range;
    logic        ram_hit;

    logic        rsp_valid_q;
    host_e       rsp_host_q;
    logic        rsp_err_q;

    // Requests are masked in reset so grants and ram_req_o read zero while rst_ni is low.
    assign req = {instr_req_i, data_req_i} & {2{rst_ni}};

    ram_arb_rr2 u_rr2 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req),
        .gnt    (gnt)
    );

    always_comb begin
        granted   = |gnt;
        winner    = gnt[1] ? HostInstr : HostData;
        sel_addr  = gnt[1] ? instr_addr_i : data_addr_i;
        sel_we    = gnt[1] ? 1'b0 : data_we_i;
        sel_be    = gnt[1] ? 4'hF : data_be_i;
        sel_wdata = gnt[1] ? 32'h0 : data_wdata_i;
        sel_in_range = in_range(sel_addr, BaseAddr, Depth);
        ram_hit   = granted && sel_in_range;
    end

    assign data_gnt_o  = gnt[0];
    assign instr_gnt_o = gnt[1];

    assign ram_req_o   = ram_hit;
    assign ram_we_o    = ram_hit && sel_we;
    assign ram_be_o    = ram_hit ? sel_be    : 4'h0;
    assign ram_addr_o  = ram_hit ? sel_addr  : 32'h0;
    assign ram_wdata_o = ram_hit ? sel_wdata : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_host_q  <= HostData;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= granted;
            rsp_host_q  <= granted ? winner : HostData;
            rsp_err_q   <= granted && !sel_in_range;
        end
    end

    // Only the host that owns the outstanding response sees anything on its return path.
    assign data_rvalid_o  = rsp_valid_q && (rsp_host_q == HostData);
    assign data_err_o     = data_rvalid_o && rsp_err_q;
    assign data_rdata_o   = (data_rvalid_o && !rsp_err_q) ? ram_rdata_i : 32'h0;

    assign instr_rvalid_o = rsp_valid_q && (rsp_host_q == HostInstr);
    assign instr_err_o    = instr_rvalid_o && rsp_err_q;
    assign instr_rdata_o  = (instr_rvalid_o && !rsp_err_q) ? ram_rdata_i : 32'h0;

    ram_rvalid_matches_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ram_rvalid_i == (rsp_valid_q && !rsp_err_q));

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Self-checking bench: reset/ordering sequences, a vector table, and randomized traffic
// against an abstract model of grant order, window decoding and memory contents.
module tb_ram_1p_arbiter;

    localparam int unsigned DEPTH = 128;
    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          NV    = 10;
    localparam int          NRAND = 400;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        instr_req_i = 1'b0;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_rvalid_i = 1'b0;
    logic [31:0] ram_rdata_i  = 32'h0;

    int checks   = 0;
    int failures = 0;

    ram_1p_arbiter #(.Depth(DEPTH), .BaseAddr(BASE)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .ram_req_o      (ram_req_o),
        .ram_we_o       (ram_we_o),
        .ram_be_o       (ram_be_o),
        .ram_addr_o     (ram_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_rvalid_i   (ram_rvalid_i),
        .ram_rdata_i    (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural single-port RAM, one-cycle latency; writes return zero data.
    logic [31:0] ram_mem [DEPTH];
    wire  [31:0] ram_off = ram_addr_o - BASE;
    wire  [6:0]  ram_idx = ram_off[8:2];

    always @(posedge clk_i) begin
        ram_rvalid_i <= ram_req_o;
        if (ram_req_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) ram_mem[ram_idx][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
                ram_rdata_i <= 32'h0;
            end else begin
                ram_rdata_i <= ram_mem[ram_idx];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic ri, input logic we, input logic [3:0] be,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] ai);
        data_req_i   = rd;
        instr_req_i  = ri;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = ad;
        data_wdata_i = wd;
        instr_addr_i = ai;
    endtask

    task automatic chk_rsp(input string tag, input logic rv_d, input logic rv_i,
                           input logic err, input logic [31:0] rdata);
        chk({tag, "_rvalid_d"}, data_rvalid_o, rv_d);
        chk({tag, "_rvalid_i"}, instr_rvalid_o, rv_i);
        chk({tag, "_err_d"}, data_err_o, rv_d && err);
        chk({tag, "_err_i"}, instr_err_o, rv_i && err);
        chk({tag, "_rdata_d"}, data_rdata_o, rv_d ? rdata : 32'h0);
        chk({tag, "_rdata_i"}, instr_rdata_o, rv_i ? rdata : 32'h0);
    endtask

    typedef struct {
        logic        req_d, req_i, we;
        logic [3:0]  be;
        logic [31:0] addr_d, wdata, addr_i;
        logic        gnt_d, gnt_i, ram_req;
        logic        rv_d, rv_i, err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic rd, logic ri, logic we, logic [3:0] be, logic [31:0] ad,
                                logic [31:0] wd, logic [31:0] ai, logic gd, logic gi, logic rr,
                                logic rvd, logic rvi, logic er, logic [31:0] rdt);
        vec_t v;
        v.req_d = rd; v.req_i = ri; v.we = we; v.be = be;
        v.addr_d = ad; v.wdata = wd; v.addr_i = ai;
        v.gnt_d = gd; v.gnt_i = gi; v.ram_req = rr;
        v.rv_d = rvd; v.rv_i = rvi; v.err = er; v.rdata = rdt;
        return v;
    endfunction

    // Reference model state for the random phase.
    logic [31:0] ref_mem [DEPTH];
    int          grant_hist [$];
    logic        pend_valid;
    int          pend_host;
    logic        pend_err;
    logic [31:0] pend_rdata;

    function automatic bit ref_in_range(input logic [31:0] a);
        longint lo, hi;
        lo = longint'(BASE);
        hi = lo + longint'(DEPTH) * 4;
        return (longint'(a) >= lo) && (longint'(a) < hi);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 32'(4 * $urandom_range(1, 8));
        if (r == 1) return BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 8));
        if (r == 2) return 32'hFFFF_FFFC;
        return BASE + 32'(4 * $urandom_range(16, DEPTH - 1)) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt_d, cnt_i;
        logic held_d, held_i;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // Reset with both hosts requesting: nothing may be granted or returned.
        drive(1, 1, 0, 4'hF, BASE, 32'h0, BASE + 4);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_gnt_d", data_gnt_o, 0);
        chk("rst_gnt_i", instr_gnt_o, 0);
        chk("rst_ram_req", ram_req_o, 0);
        chk_rsp("rst", 0, 0, 0, 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("tie_after_rst_gnt_d", data_gnt_o, 1);
        chk("tie_after_rst_gnt_i", instr_gnt_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("tie2_gnt_i", instr_gnt_o, 1);
        chk("tie2_gnt_d", data_gnt_o, 0);
        chk_rsp("tie2", 1, 0, 0, 0);
        @(posedge clk_i); #1 drive(0, 0, 0, 4'h0, 0, 0, 0);
        @(negedge clk_i);
        chk("tie3_gnt_d", data_gnt_o, 0);
        chk_rsp("tie3", 0, 1, 0, 0);

        // Vector table: arbitration order continues from the instr grant above.
        vecs[0] = mk(1, 0, 1, 4'hF, BASE + 4,  32'hDEADBEEF, 0,         1, 0, 1, 1, 0, 0, 0);
        vecs[1] = mk(0, 1, 0, 4'h0, 0,         0,            BASE + 4,  0, 1, 1, 0, 1, 0, 32'hDEADBEEF);
        vecs[2] = mk(1, 1, 0, 4'hF, BASE + 4,  0,            BASE + 8,  1, 0, 1, 1, 0, 0, 32'hDEADBEEF);
        vecs[3] = mk(1, 1, 1, 4'h3, BASE + 8,  32'h12345678, BASE + 8,  0, 1, 1, 0, 1, 0, 0);
        vecs[4] = mk(1, 0, 1, 4'h3, BASE + 8,  32'h12345678, 0,         1, 0, 1, 1, 0, 0, 0);
        vecs[5] = mk(0, 1, 0, 4'h0, 0,         0,            BASE + 8,  0, 1, 1, 0, 1, 0, 32'h0000_5678);
        vecs[6] = mk(0, 1, 0, 4'h0, 0,         0,            32'h0010_0200, 0, 1, 0, 0, 1, 1, 0);
        vecs[7] = mk(1, 0, 0, 4'hF, 32'h000F_FFFC, 0,        0,         1, 0, 0, 1, 0, 1, 0);
        vecs[8] = mk(1, 0, 0, 4'hF, 32'h0010_01FC, 0,        0,         1, 0, 1, 1, 0, 0, 0);
        vecs[9] = mk(0, 0, 0, 4'h0, 0,         0,            0,         0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NV; k++) begin
            @(posedge clk_i); #1;
            drive(vecs[k].req_d, vecs[k].req_i, vecs[k].we, vecs[k].be,
                  vecs[k].addr_d, vecs[k].wdata, vecs[k].addr_i);
            @(negedge clk_i);
            chk($sformatf("vec%0d_gnt_d", k), data_gnt_o, vecs[k].gnt_d);
            chk($sformatf("vec%0d_gnt_i", k), instr_gnt_o, vecs[k].gnt_i);
            chk($sformatf("vec%0d_ram_req", k), ram_req_o, vecs[k].ram_req);
            if (vecs[k].ram_req) begin
                chk($sformatf("vec%0d_ram_addr", k), ram_addr_o,
                    vecs[k].gnt_i ? vecs[k].addr_i : vecs[k].addr_d);
            end
            if (k > 0) begin
                chk_rsp($sformatf("vec%0d_rsp", k - 1), vecs[k-1].rv_d, vecs[k-1].rv_i,
                        vecs[k-1].err, vecs[k-1].rdata);
            end
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk_rsp("vec_last_rsp", vecs[NV-1].rv_d, vecs[NV-1].rv_i, vecs[NV-1].err, vecs[NV-1].rdata);

        // Sustained contention: last table grant was data, so instr leads.
        cnt_d = 0;
        cnt_i = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_i); #1 drive(1, 1, 0, 4'hF, BASE + 16, 0, BASE + 20);
            @(negedge clk_i);
            chk($sformatf("contend%0d_gnt_i", k), instr_gnt_o, (k % 2) == 0);
            chk($sformatf("contend%0d_gnt_d", k), data_gnt_o, (k % 2) == 1);
            if (k > 0) chk_rsp($sformatf("contend%0d_rsp", k), (k % 2) == 0, (k % 2) == 1, 0, 0);
            cnt_d += int'(data_gnt_o);
            cnt_i += int'(instr_gnt_o);
        end
        chk("contend_count_d", cnt_d, 5);
        chk("contend_count_i", cnt_i, 5);
        @(posedge clk_i); #1 drive(0, 0, 0, 4'h0, 0, 0, 0);
        @(negedge clk_i);

        // Reset mid-flight: the response of an accepted access must vanish.
        @(posedge clk_i); #1 drive(1, 0, 0, 4'hF, BASE + 4, 0, 0);
        @(negedge clk_i);
        chk("mid_gnt_d", data_gnt_o, 1);
        @(posedge clk_i); #1 rst_ni = 1'b0;
        drive(0, 0, 0, 4'h0, 0, 0, 0);
        #1;
        chk("mid_rvalid_d", data_rvalid_o, 0);
        chk("mid_rvalid_i", instr_rvalid_o, 0);
        @(negedge clk_i);
        chk_rsp("mid_neg", 0, 0, 0, 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        drive(1, 1, 0, 4'hF, BASE, 0, BASE + 4);
        @(negedge clk_i);
        chk("mid_tie_gnt_d", data_gnt_o, 1);
        chk("mid_tie_gnt_i", instr_gnt_o, 0);
        chk_rsp("mid_after", 0, 0, 0, 0);

        // Fresh reset before randomized traffic so the model starts with an empty history.
        @(posedge clk_i); #1 rst_ni = 1'b0;
        drive(0, 0, 0, 4'h0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        pend_valid = 1'b0;
        pend_host  = 0;
        pend_err   = 1'b0;
        pend_rdata = 32'h0;
        held_d = 1'b0;
        held_i = 1'b0;
        for (int c = 0; c < NRAND; c++) begin
            int          w, pref, idx;
            bit          inr, is_wr;
            logic [31:0] a, cur;
            @(posedge clk_i); #1;
            if (!held_d) begin
                data_req_i   = ($urandom_range(0, 3) != 0);
                data_we_i    = $urandom_range(0, 1) == 1;
                data_be_i    = 4'($urandom_range(0, 15));
                data_addr_i  = rand_addr();
                data_wdata_i = $urandom;
            end
            if (!held_i) begin
                instr_req_i  = ($urandom_range(0, 3) != 0);
                instr_addr_i = rand_addr();
            end
            @(negedge clk_i);
            chk_rsp($sformatf("rnd%0d_rsp", c), pend_valid && pend_host == 0,
                    pend_valid && pend_host == 1, pend_err, pend_rdata);
            pref = (grant_hist.size() == 0 || grant_hist[$] == 1) ? 0 : 1;
            w = -1;
            if (data_req_i && instr_req_i) w = pref;
            else if (data_req_i)           w = 0;
            else if (instr_req_i)          w = 1;
            chk($sformatf("rnd%0d_gnt_d", c), data_gnt_o, w == 0);
            chk($sformatf("rnd%0d_gnt_i", c), instr_gnt_o, w == 1);
            held_d = data_req_i && (w != 0);
            held_i = instr_req_i && (w != 1);
            pend_valid = (w >= 0);
            pend_host  = (w < 0) ? 0 : w;
            pend_err   = 1'b0;
            pend_rdata = 32'h0;
            if (w >= 0) begin
                grant_hist.push_back(w);
                a     = (w == 1) ? instr_addr_i : data_addr_i;
                is_wr = (w == 0) && data_we_i;
                inr   = ref_in_range(a);
                chk($sformatf("rnd%0d_ram_req", c), ram_req_o, inr);
                pend_err = !inr;
                if (inr) begin
                    idx = int'((a - BASE) / 4);
                    chk($sformatf("rnd%0d_ram_addr", c), ram_addr_o, a);
                    chk($sformatf("rnd%0d_ram_we", c), ram_we_o, is_wr);
                    chk($sformatf("rnd%0d_ram_be", c), ram_be_o, (w == 1) ? 4'hF : data_be_i);
                    if (is_wr) begin
                        chk($sformatf("rnd%0d_ram_wdata", c), ram_wdata_o, data_wdata_i);
                        cur = ref_mem[idx];
                        for (int b = 0; b < 4; b++) begin
                            if (data_be_i[b]) cur[8*b +: 8] = data_wdata_i[8*b +: 8];
                        end
                        ref_mem[idx] = cur;
                    end else begin
                        pend_rdata = ref_mem[idx];
                    end
                end
            end else begin
                chk($sformatf("rnd%0d_ram_req_idle", c), ram_req_o, 0);
            end
        end
        @(posedge clk_i); #1 drive(0, 0, 0, 4'h0, 0, 0, 0);
        @(negedge clk_i);
        chk_rsp("rnd_last_rsp", pend_valid && pend_host == 0, pend_valid && pend_host == 1,
                pend_err, pend_rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_1p_arbiter.md
# ram_1p_arbiter

Two-host arbiter that shares one single-port, one-cycle-latency word RAM between the core's instruction-fetch port and its data port in the simple-system top. Each host sees its own request/grant/rvalid interface. The arbiter grants one access per cycle with round-robin fairness and steers each RAM read response back to the host that issued it. Addresses outside the RAM window are answered locally with an error response and never reach the RAM.

## Interface
- `Depth`, 128: RAM depth in 32-bit words. Must be a power of two, ≥ 2.
- `BaseAddr`, 32'h0010_0000: byte base address of the RAM window. Aligned to `Depth*4`.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `data_req_i` in 1: data host request.
- `data_gnt_o` out 1: data request accepted this cycle. Combinational from the requests.
- `data_we_i` in 1: write enable.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_rvalid_o` out 1: response valid. Given for writes as well as reads.
- `data_rdata_o` out 32: read data. Zero on error.
- `data_err_o` out 1: error flag, qualified by `data_rvalid_o`.
- `instr_req_i` in 1: fetch request. Read-only.
- `instr_gnt_o` out 1: fetch accepted.
- `instr_addr_i` in 32: fetch byte address.
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out 32: fetch data.
- `instr_err_o` out 1: fetch error.
- `ram_req_o` out 1: RAM request.
- `ram_we_o` out 1: RAM write enable.
- `ram_be_o` out 4: RAM byte enables.
- `ram_addr_o` out 32: RAM byte address. Passed through unchanged.
- `ram_wdata_o` out 32: RAM write data.
- `ram_rvalid_i` in 1: RAM response valid.
- `ram_rdata_i` in 32: RAM read data.

## Operation
- **In range:** `addr >= BaseAddr && addr < BaseAddr + Depth*4`. Compare with 32-bit unsigned arithmetic. `addr[1:0]` is ignored.
- **Arbitration:** round-robin pointer `prio_q` names the preferred host. Reset value: data.
  - One requester: it is granted.
  - Both requesting: the `prio_q` host is granted.
  - On every grant, `prio_q` moves to the other host.
- **Hold rule:** an ungranted host keeps its request and attributes stable. The arbiter does not latch them.
- **Granted and in range:** `ram_req_o` = 1 and `ram_*` are driven from the winner's signals. For instr the drive is `we`=0 and `be`=4'hF.
- **Granted and out of range:** `ram_req_o` = 0. An error response is queued.
- **Response state:** registered `rsp_valid_q`, `rsp_host_q`, `rsp_err_q`. These are loaded on every grant and cleared when there is no grant.
- **Response routing:**
  - `<host>_rvalid_o` = `rsp_valid_q && rsp_host_q == host`.
  - `err` = `rsp_err_q`.
  - `rdata` = `ram_rdata_i` on success, 0 on error.
  - The non-selected host sees rvalid = 0, err = 0, rdata = 0.
- **RAM contract:** `ram_rvalid_i` must equal `rsp_valid_q && !rsp_err_q` every cycle. This is checked by assertion only and is not used for routing.
- **No grant:** `ram_req_o` = 0. All other `ram_*` outputs are 0.

## Timing
- **Reset values:** all `*_gnt_o`, `*_rvalid_o`, `*_err_o` and `ram_req_o` = 0. All data outputs = 0. `prio_q` = data. Response registers cleared.
- **Grant:** same cycle as the request, combinational. Response comes exactly 1 cycle after the grant, for both RAM and error paths.
- **Throughput:** one grant per cycle, sustained. With both hosts requesting continuously, grants strictly alternate.
- **Simultaneous events:** a response for access N and the grant of access N+1 occur in the same cycle with no bubble.
- **Reset mid-operation:** an outstanding response is dropped with no rvalid. The RAM may still complete the access internally; its response is ignored.
- **Tie after reset:** data wins.

## Structure
- Package `ram_arb_pkg`:
  - enum `host_e` {`HostData`=0, `HostInstr`=1}.
  - `RamWordBytes`=4.
  - function `in_range(addr, base, depth)`.
- Sub-module `ram_arb_rr2`: 2-way round-robin picker containing `prio_q`. Inputs: `req[1:0]`. Outputs: one-hot `gnt[1:0]`. Its async reset follows `rst_ni`.
- Top level: range check, request mux, response registers, output steering.

## Test plan
All scenarios use `BaseAddr`=0x0010_0000 and `Depth`=128.
- **Reset:** hold `rst_ni`=0 with both requests high → all gnt/rvalid/`ram_req_o` = 0. Release → first tie is granted to data.
- **Data write then fetch:** data write 0xDEADBEEF, `be`=4'hF, to 0x0010_0004, then fetch 0x0010_0004 → data rvalid with err=0 on the cycle after its grant; instr rdata = 0xDEADBEEF.
- **Simultaneous requests:** both hosts request on cycle 0 → cycle 0 grants data, cycle 1 grants instr. Responses arrive on cycles 1 and 2, each only on its own host port.
- **Sustained contention:** 10 cycles with both requesting → exactly 5 grants each, alternating.
- **Out of range:** fetch 0x0010_0200 and data read 0x000F_FFFC → `ram_req_o` stays 0; next cycle rvalid=1, err=1, rdata=0.
- **Reset mid-flight:** assert `rst_ni` on the cycle after a grant → no rvalid on either host; the next tie goes to data.
